ee457_if_stage: RTL and testbench
=================================

# ee457_if_stage

Instruction-fetch stage and IF/ID pipeline register for the ee457 five-stage pipeline. Sits directly upstream of ID and the hazard detection unit: it consumes `pcwrite`/`irwrite` from the HDU and the taken-branch redirect from EX. It drives a request/ready instruction-memory port and presents the fetched instruction and PC+4 to ID. A one-entry hold buffer and a drop state tolerate variable memory latency, load-use stalls and mid-fetch redirects.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pcwrite`  in  1  from HDU; 0 = hold PC
- `irwrite`  in  1  from HDU; 0 = hold IF/ID
- `br_taken`  in  1  taken branch/jump resolved in EX
- `br_target`  in  32  redirect address, word-aligned
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and not accepted
- `imem_rdy`  in  1  read completes this cycle (meaningful only with `imem_req`=1)
- `imem_rdata`  in  32  instruction, valid when `imem_req`&`imem_rdy`
- `if_id_instr`  out  32  IF/ID instruction; 32'h0 (NOP) when invalid
- `if_id_pc4`  out  32  IF/ID PC+4
- `if_id_valid`  out  1  IF/ID holds a real instruction

## Operation
- State: `pc` (32), `req_addr` (32), `buf_instr` (32), FSM {REQ, HOLD, DROP}.
- Reset: `pc`=`req_addr`=RESET_PC, FSM=REQ, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc4`=0, `buf_instr`=0. `imem_req`=0 while `rst`=1.
- `imem_req` = 1 in REQ and DROP, 0 in HOLD. `imem_addr` = `req_addr`.
- Accept = `imem_req` & `imem_rdy` at a rising edge.
- REQ, accept, `irwrite`=1: IF/ID <= {`imem_rdata`, `pc`+4, valid 1}. If `pcwrite`=1, `pc` and `req_addr` <= `pc`+4. Stay REQ.
- REQ, accept, `irwrite`=0: `buf_instr` <= `imem_rdata`; IF/ID unchanged; `pc` unchanged; go to HOLD.
- REQ, no accept, `irwrite`=1: IF/ID <= bubble (valid 0, instr 0, pc4 0).
- REQ, no accept, `irwrite`=0: IF/ID holds.
- HOLD, `irwrite`=0: everything holds.
- HOLD, `irwrite`=1: IF/ID <= {`buf_instr`, `pc`+4, 1}. If `pcwrite`=1, `pc`/`req_addr` <= `pc`+4. Go to REQ.
- `br_taken`=1 has priority over stall and fetch in every state:
  - IF/ID <= bubble; `pc` <= `br_target`; `buf_instr` discarded.
  - REQ with accept, or HOLD: `req_addr` <= `br_target`, go to REQ.
  - REQ without accept: `req_addr` held (an issued request is never cancelled); go to DROP.
  - DROP: `pc` <= `br_target`, stay DROP.
- DROP without accept: hold. DROP with accept: discard `imem_rdata`, `req_addr` <= `pc`, go to REQ. IF/ID stays bubble unless `irwrite`=0 held it.
- `pcwrite`≠`irwrite` is not produced by the HDU; each enable still gates only its own register.
- Arithmetic: PC+4 is modulo 2^32 (0xFFFF_FFFC+4 = 0). No alignment checking.

## Timing
- Zero-wait memory (`imem_rdy` tied 1): one instruction per cycle. The first instruction is valid in IF/ID in the 2nd cycle after `rst` falls.
- N wait states: N bubbles per instruction.
- Load-use stall: IF/ID and PC frozen for each cycle `irwrite`=0. No instruction is lost or duplicated.
- Taken branch: the following cycle shows a bubble in IF/ID. The target instruction appears 1 cycle after the target request is accepted.
- `rst` mid-request: the outstanding fetch is abandoned, and the memory must tolerate `imem_req` dropping.

## Structure
- Shared package `ee457_pkg`:
  - `NOP_INSTR` = 32'h0
  - FSM state encoding for {REQ, HOLD, DROP}
  - default `RESET_PC`
- Sub-module `ee457_if_id_reg`: enable/flush register for {instr, pc4, valid}. Flush has priority over enable, and flush loads the bubble.

## Test plan
- Reset release, `imem_rdy`=1, memory word = address: IF/ID sequence 0,4,8… with pc4 4,8,12…; `imem_addr` RESET_PC on the first `imem_req` cycle.
- `irwrite`=`pcwrite`=0 for 2 cycles while the instruction at 0x8 is accepted: IF/ID holds 0x4 for 2 cycles, then shows 0x8 then 0xC; no duplicate and no skip.
- `imem_rdy` delayed 3 cycles per fetch: 3 bubbles (valid 0, instr 0) between instructions; `imem_addr` stable throughout.
- `br_taken`, target 0x100, in the same cycle as the 0x10 accept: the 0x10 fetch is discarded, IF/ID shows a bubble, then 0x100 with pc4 0x104.
- `br_taken`, target 0x200, while the 0x20 request has `imem_rdy`=0: FSM enters DROP and `imem_addr` stays 0x20 until rdy. Data at 0x20 is never in IF/ID, and the next request is 0x200.
- `br_taken` and `irwrite`=0 in the same cycle during HOLD: bubble loads, the buffer is discarded, and the next fetch is `br_target`.

Source files
------------

// File: rtl/ee457_pkg.sv
// Shared types and constants for the ee457 fetch stage: fetch FSM encoding,
// the IF/ID payload struct and the bubble value.
package ee457_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } fetch_st_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/ee457_if_id_reg.sv
// IF/ID pipeline register: flush (bubble) wins over enable, enable 0 holds.
module ee457_if_id_reg
  import ee457_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  always_ff @(posedge clk) begin
    if (rst || flush_i) q_o <= IF_ID_BUBBLE;
    else if (en_i)      q_o <= d_i;
  end

endmodule

// File: rtl/ee457_if_stage.sv
// Instruction fetch with a one-entry hold buffer (load-use stalls) and a drop
// state that swallows a fetch already in flight when a branch redirects.
module ee457_if_stage
  import ee457_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcwrite,
  input  logic        irwrite,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  fetch_st_e   st_q, st_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc4;
  logic        accept;
  logic        ifid_en, ifid_flush;
  if_id_t      ifid_d, ifid_q;

  assign pc4       = pc_q + 32'd4;
  assign imem_req  = ~rst & (st_q != ST_HOLD);
  assign imem_addr = req_addr_q;
  assign accept    = imem_req & imem_rdy;

  always_comb begin
    st_d       = st_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    ifid_d     = '{instr: imem_rdata, pc4: pc4, valid: 1'b1};
    if (br_taken) begin
      ifid_flush = 1'b1;
      pc_d       = br_target;
      buf_d      = NOP_INSTR;
      case (st_q)
        ST_REQ: begin
          // An issued request cannot be withdrawn; without accept we must
          // let it complete and throw the data away.
          if (accept) req_addr_d = br_target;
          else        st_d       = ST_DROP;
        end
        ST_HOLD: begin
          req_addr_d = br_target;
          st_d       = ST_REQ;
        end
        default: st_d = ST_DROP;
      endcase
    end else begin
      case (st_q)
        ST_REQ: begin
          if (accept) begin
            if (irwrite) begin
              ifid_en = 1'b1;
              if (pcwrite) begin
                pc_d       = pc4;
                req_addr_d = pc4;
              end
            end else begin
              buf_d = imem_rdata;
              st_d  = ST_HOLD;
            end
          end else if (irwrite) begin
            ifid_flush = 1'b1;
          end
        end
        ST_HOLD: begin
          if (irwrite) begin
            ifid_en = 1'b1;
            ifid_d  = '{instr: buf_q, pc4: pc4, valid: 1'b1};
            st_d    = ST_REQ;
            if (pcwrite) begin
              pc_d       = pc4;
              req_addr_d = pc4;
            end
          end
        end
        default: begin
          ifid_flush = irwrite;
          if (accept) begin
            req_addr_d = pc_q;
            st_d       = ST_REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_q      <= NOP_INSTR;
    end else begin
      st_q       <= st_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
    end
  end

  ee457_if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ifid_en),
    .flush_i (ifid_flush),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign if_id_instr = ifid_q.instr;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_ee457_if_stage.sv
// Self-checking bench for ee457_if_stage: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a model.
module tb_ee457_if_stage;

  logic        clk = 1'b0;
  logic        rst, pcwrite, irwrite, br_taken, imem_rdy;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: each word holds its own address.
  assign imem_rdata = imem_addr;

  ee457_if_stage #(.RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .pcwrite     (pcwrite),
    .irwrite     (irwrite),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_rdata  (imem_rdata),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: "waiting" = an instruction fetched during a stall is
  // parked; "discard" = the next completed fetch belongs to a dead path.
  logic [31:0] m_pc, m_addr, m_buf, m_i, m_p4;
  bit          m_waiting, m_discard, m_v;
  bit          started = 0;

  always @(posedge clk) begin : model
    bit          acc;
    logic [31:0] data;
    logic [31:0] nxt;
    if (rst) begin
      m_pc = 0; m_addr = 0; m_buf = 0;
      m_waiting = 0; m_discard = 0;
      m_v = 0; m_i = 0; m_p4 = 0;
      started = 1;
    end else if (started) begin
      acc  = !m_waiting && imem_rdy;
      data = m_addr;
      nxt  = m_pc + 32'd4;
      if (br_taken) begin
        m_v = 0; m_i = 0; m_p4 = 0;
        m_pc = br_target;
        if (!m_discard && (m_waiting || acc)) begin
          m_addr = br_target;
          m_waiting = 0;
        end else begin
          m_discard = 1;
        end
      end else if (m_waiting) begin
        if (irwrite) begin
          m_v = 1; m_i = m_buf; m_p4 = nxt;
          m_waiting = 0;
          if (pcwrite) begin m_pc = nxt; m_addr = nxt; end
        end
      end else if (m_discard) begin
        if (irwrite) begin m_v = 0; m_i = 0; m_p4 = 0; end
        if (acc) begin m_addr = m_pc; m_discard = 0; end
      end else if (acc) begin
        if (irwrite) begin
          m_v = 1; m_i = data; m_p4 = nxt;
          if (pcwrite) begin m_pc = nxt; m_addr = nxt; end
        end else begin
          m_buf = data;
          m_waiting = 1;
        end
      end else if (irwrite) begin
        m_v = 0; m_i = 0; m_p4 = 0;
      end
    end
  end

  // Compare process, sampled on the falling edge.
  bit          p_pend = 0;
  logic [31:0] p_addr = 0;
  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(if_id_valid), 32'(m_v));
      chk("instr", if_id_instr, m_i);
      chk("pc4", if_id_pc4, m_p4);
      chk("imem_req", 32'(imem_req), 32'(!rst && !m_waiting));
      if (imem_req) chk("imem_addr", imem_addr, m_addr);
      if (if_id_valid) chk("stream_pc4", if_id_instr + 32'd4, if_id_pc4);
      if (p_pend && imem_req) chk("addr_stable", imem_addr, p_addr);
      p_pend = imem_req && !imem_rdy && !rst;
      p_addr = imem_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; pcwrite = 1; irwrite = 1; br_taken = 0; br_target = 0; imem_rdy = 1;
    repeat (3) step();
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    rst = 0;
    #1;
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    step();
    chk("seq0_instr", if_id_instr, 32'h0);
    chk("seq0_pc4", if_id_pc4, 32'h4);
    chk("seq0_valid", 32'(if_id_valid), 32'h1);
    step();
    chk("seq1_instr", if_id_instr, 32'h4);
    chk("seq1_pc4", if_id_pc4, 32'h8);
    // Load-use stall while 0x8 is being accepted
    irwrite = 0; pcwrite = 0;
    step();
    chk("stall1_instr", if_id_instr, 32'h4);
    chk("stall1_req", 32'(imem_req), 32'h0);
    step();
    chk("stall2_instr", if_id_instr, 32'h4);
    irwrite = 1; pcwrite = 1;
    step();
    chk("unstall_instr", if_id_instr, 32'h8);
    chk("unstall_pc4", if_id_pc4, 32'hC);
    step();
    chk("after_stall_instr", if_id_instr, 32'hC);
    chk("after_stall_addr", imem_addr, 32'h10);
    // Branch together with the 0x10 accept
    br_taken = 1; br_target = 32'h100;
    step();
    chk("br_acc_valid", 32'(if_id_valid), 32'h0);
    chk("br_acc_instr", if_id_instr, 32'h0);
    chk("br_acc_addr", imem_addr, 32'h100);
    br_taken = 0;
    step();
    chk("tgt_instr", if_id_instr, 32'h100);
    chk("tgt_pc4", if_id_pc4, 32'h104);
    // Three wait states
    imem_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_valid", 32'(if_id_valid), 32'h0);
      chk("ws_instr", if_id_instr, 32'h0);
      chk("ws_addr", imem_addr, 32'h104);
    end
    imem_rdy = 1;
    step();
    chk("ws_done_instr", if_id_instr, 32'h104);
    // Branch while the 0x108 request is outstanding
    imem_rdy = 0; br_taken = 1; br_target = 32'h200;
    step();
    chk("drop_valid", 32'(if_id_valid), 32'h0);
    chk("drop_req", 32'(imem_req), 32'h1);
    chk("drop_addr", imem_addr, 32'h108);
    br_taken = 0;
    step();
    chk("drop_addr2", imem_addr, 32'h108);
    imem_rdy = 1;
    step();
    chk("drop_done_valid", 32'(if_id_valid), 32'h0);
    chk("drop_done_addr", imem_addr, 32'h200);
    step();
    chk("drop_tgt_instr", if_id_instr, 32'h200);
    chk("drop_tgt_pc4", if_id_pc4, 32'h204);
    // Branch during HOLD
    irwrite = 0; pcwrite = 0;
    step();
    chk("hold_req", 32'(imem_req), 32'h0);
    chk("hold_instr", if_id_instr, 32'h200);
    br_taken = 1; br_target = 32'h300;
    step();
    chk("hold_br_valid", 32'(if_id_valid), 32'h0);
    chk("hold_br_req", 32'(imem_req), 32'h1);
    chk("hold_br_addr", imem_addr, 32'h300);
    br_taken = 0; irwrite = 1; pcwrite = 1;
    step();
    chk("hold_tgt_instr", if_id_instr, 32'h300);
    chk("hold_tgt_pc4", if_id_pc4, 32'h304);
    // PC+4 wraps modulo 2^32
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    br_taken = 0;
    step();
    chk("wrap_instr", if_id_instr, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    // Randomized traffic, including occasional mid-request resets
    repeat (3000) begin
      rst       = ($urandom_range(0, 99) == 0);
      br_taken  = ($urandom_range(0, 7) == 0);
      br_target = $urandom & 32'hFFFF_FFFC;
      irwrite   = ($urandom_range(0, 3) != 0);
      pcwrite   = irwrite;
      imem_rdy  = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0; br_taken = 0; irwrite = 1; pcwrite = 1; imem_rdy = 1;
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
